// File: rtl/rec_deser_if.sv
// Link and parallel-port bundle for rec_deser.
// master = the receiver itself; slave = the source/consumer environment around it.
interface rec_deser_if;
  logic        EN;
  logic        SER_REQ;
  logic        SER_ACK;
  logic        SER_DATA;
  logic        OUT_VALID;
  logic [7:0]  OUT_DATA;
  logic        OUT_READY;
  logic        ERR;
  logic        CLR_ERR;
  logic [15:0] BYTE_CNT;

  modport master (
    input  EN, SER_ACK, SER_DATA, OUT_READY, CLR_ERR,
    output SER_REQ, OUT_VALID, OUT_DATA, ERR, BYTE_CNT
  );
  modport slave (
    output EN, SER_ACK, SER_DATA, OUT_READY, CLR_ERR,
    input  SER_REQ, OUT_VALID, OUT_DATA, ERR, BYTE_CNT
  );
endinterface

// File: rtl/rec_deser.sv
// Serial request/ack receiver: pulls 8-bit words LSB-first, queues them in a
// small circular FIFO and presents them on a valid/ready port with a sticky error flag.
module rec_deser #(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RSTB,
  rec_deser_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, SHIFT} state_e;

  state_e                  state_q, state_d;
  logic                    req_q, req_d;
  logic [TW-1:0]           tcnt_q, tcnt_d;
  logic [7:0]              sr_q, sr_d;
  logic [2:0]              idx_q, idx_d;
  logic                    err_q, err_d;
  logic [15:0]             bcnt_q;
  logic [DEPTH-1:0][7:0]   mem_q;
  logic [PW-1:0]           wr_q, rd_q;
  logic [CW-1:0]           cnt_q;
  logic                    push, pop, err_ev;
  logic [7:0]              word;

  assign pop  = (cnt_q != '0) && bus.OUT_READY;
  assign word = {bus.SER_DATA, sr_q[6:0]};

  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    tcnt_d  = tcnt_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    push    = 1'b0;
    err_ev  = 1'b0;
    case (state_q)
      IDLE: begin
        err_ev = bus.SER_ACK;
        if (bus.EN && (cnt_q < CW'(DEPTH))) begin
          state_d = REQ;
          req_d   = 1'b1;
        end
      end
      REQ: begin
        err_ev  = bus.SER_ACK;
        state_d = WAIT_ACK;
        tcnt_d  = '0;
      end
      WAIT_ACK: begin
        if (bus.SER_ACK) begin
          sr_d    = {7'd0, bus.SER_DATA};
          idx_d   = 3'd1;
          state_d = SHIFT;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          err_ev  = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      SHIFT: begin
        // A second ACK mid-word means the source lost framing; drop the word.
        if (bus.SER_ACK) begin
          err_ev  = 1'b1;
          sr_d    = '0;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          sr_d[idx_q] = bus.SER_DATA;
          idx_d       = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            push    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    err_d = err_ev ? 1'b1 : (bus.CLR_ERR ? 1'b0 : err_q);
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      tcnt_q  <= '0;
      sr_q    <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      tcnt_q  <= tcnt_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Overflow cannot happen: requests are only issued with a free slot.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      mem_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      bcnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= word;
        wr_q        <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
        bcnt_q      <= bcnt_q + 16'd1;
      end
      if (pop)
        rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  assign bus.SER_REQ   = req_q;
  assign bus.OUT_VALID = (cnt_q != '0);
  assign bus.OUT_DATA  = (cnt_q != '0) ? mem_q[rd_q] : 8'd0;
  assign bus.ERR       = err_q;
  assign bus.BYTE_CNT  = bcnt_q;
endmodule

// File: doc/rec_deser.md
# rec_deser

Serial-to-parallel receiver that sits directly downstream of the recurrent-input buffer. It pulls 8-bit words over the one-wire serial request/ack link, where the source answers a one-cycle request with ACK plus bit 0 and then bits 1..7 on the following seven cycles. It reassembles each word LSB-first and queues it in a small FIFO. It presents the words on a valid/ready parallel port to the recurrent datapath, and flags link errors.

## Interface
- DEPTH, 2: FIFO entries, ≥1.
- TIMEOUT, 16: maximum WAIT_ACK cycles before abort, ≥2.
- CLK  in  1  clock; all state updates on rising edge.
- RSTB  in  1  reset, asynchronous, active-low.
- EN  in  1  fetch enable; sampled only in IDLE.
- SER_REQ  out  1  registered request pulse to the serial source.
- SER_ACK  in  1  source ack; high exactly with bit 0.
- SER_DATA  in  1  serial data bit.
- OUT_VALID  out  1  FIFO non-empty.
- OUT_DATA  out  8  FIFO head word.
- OUT_READY  in  1  consumer accepts head when OUT_VALID=1.
- ERR  out  1  sticky link-error flag.
- CLR_ERR  in  1  clears ERR.
- BYTE_CNT  out  16  words pushed since reset; wraps 0xFFFF→0.

## Operation
- Reset values: SER_REQ=0, OUT_VALID=0, OUT_DATA=0, ERR=0, BYTE_CNT=0. FSM=IDLE, FIFO empty, shift register and counters 0. Any partial word in flight is discarded.
- FSM states: IDLE, REQ, WAIT_ACK, SHIFT.
- IDLE: if EN=1 and FIFO count<DEPTH, go to REQ and assert SER_REQ. Otherwise stay in IDLE.
- REQ: lasts exactly 1 cycle with SER_REQ=1. On exit, go to WAIT_ACK, SER_REQ=0, timeout counter=0.
- WAIT_ACK, SER_ACK=1: capture SER_DATA into bit 0, bit index=1, go to SHIFT.
- WAIT_ACK, SER_ACK=0: increment the timeout counter. When it reaches TIMEOUT-1, set ERR and go to IDLE (retry allowed).
- SHIFT: capture SER_DATA into bit[index] and increment the index.
- SHIFT, index=7: push the assembled word (bit k → OUT_DATA[k]), increment BYTE_CNT, go to IDLE.
- SHIFT, SER_ACK=1: protocol error. Set ERR, discard the word, go to IDLE.
- SER_ACK=1 in IDLE or REQ (unsolicited): set ERR, ignore the data.
- EN falling mid-word does not abort; the word completes and is pushed.
- FIFO: circular, push at tail, pop when OUT_VALID & OUT_READY. Simultaneous push and pop in one cycle are legal; the count is unchanged.
- No overflow is possible: a request is issued only with a free slot, and at most one word is in flight.
- Popping empty is a no-op.
- OUT_DATA is 0 when empty.
- CLR_ERR clears ERR. If an error event occurs in the same cycle, ERR stays 1.

## Timing
- SER_REQ high during cycle T (set at edge T, cleared at edge T+1).
- Source samples SER_REQ at edge T+1 and drives ACK and bit 0 during T+1..T+2.
- Sink captures bit 0 at edge T+2 and bits 1..7 at edges T+3..T+9.
- OUT_VALID rises after edge T+9 (9-cycle latency from SER_REQ rise).
- Next SER_REQ is earliest at edge T+10. Streaming rate is 1 word / 10 cycles.
- A pop at edge P that frees a slot lets IDLE issue SER_REQ at edge P+1.
- Unrecovered timeout: ERR rises at edge T+1+TIMEOUT.
- SER_REQ never overlaps a word in progress.

## Test plan
- Reset: hold RSTB=0 with random inputs -> all outputs 0. Release with EN=0 -> SER_REQ stays 0 for 50 cycles.
- Single word: EN=1, OUT_READY=1, bus-functional source sends 0xA5 -> one 1-cycle SER_REQ; OUT_VALID 1 for one cycle 9 cycles later with OUT_DATA=0xA5; BYTE_CNT=1; ERR=0.
- Backpressure: OUT_READY=0, source supplies 0x01, 0x02, 0x03 -> exactly 2 SER_REQ pulses and OUT_DATA=0x01 holds. Pulse OUT_READY one cycle -> head 0x02, third SER_REQ on the next edge. Drain -> 0x02, 0x03 in order; BYTE_CNT=3.
- Timeout: SER_REQ answered with no ACK -> ERR=1 exactly TIMEOUT cycles after WAIT_ACK entry, then new SER_REQ. Source responds with 0x5A -> word delivered. CLR_ERR -> ERR=0.
- Protocol errors: SER_ACK pulse with EN=0 in IDLE -> ERR=1, no push. Second ACK at bit 4 of a word -> ERR=1, word discarded, BYTE_CNT unchanged.
- Reset mid-word: assert RSTB=0 after bit 3 -> OUT_VALID=0, BYTE_CNT=0. After release, source sends 0x3C -> delivered correctly, BYTE_CNT=1.
